// File: rtl/cordic_angle_unwrap.sv
// cordic_angle_unwrap: assembles a full-circle angle from the first-quadrant
// CORDIC angle plus quadrant index, unwraps it across 0/2pi into a turn
// counter and per-sample delta, and sums deltas over a fixed window.
module cordic_angle_unwrap #(
    parameter int unsigned W_TURN    = 16,
    parameter int unsigned WIN_LOG2  = 4,
    parameter int unsigned HALF_PI_Q = 51472
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic signed [16:0]               theta_1st_quad,
    input  logic [1:0]                       quadrant,
    output logic                             out_valid,
    output logic [17:0]                      angle_out,
    output logic signed [18:0]               delta_out,
    output logic signed [W_TURN-1:0]         turn_cnt,
    output logic                             sat_flag,
    output logic                             speed_valid,
    output logic signed [19+WIN_LOG2-1:0]    speed_out
);

    localparam int unsigned ANG_W   = 18;
    localparam int unsigned DELTA_W = 19;
    localparam int unsigned SPD_W   = DELTA_W + WIN_LOG2;
    localparam int unsigned PI_Q    = 2 * HALF_PI_Q;
    localparam int unsigned TWO_PI  = 4 * HALF_PI_Q;

    localparam logic signed [16:0]        HALF_PI_TH = 17'(HALF_PI_Q);
    localparam logic [ANG_W-1:0]          TWO_PI_A   = ANG_W'(TWO_PI);
    localparam logic signed [DELTA_W-1:0] PI_D       = DELTA_W'(PI_Q);
    localparam logic signed [DELTA_W-1:0] TWO_PI_D   = DELTA_W'(TWO_PI);

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // stage-1 registers
    logic                      s1_valid_q, s1_valid_d;
    logic [ANG_W-1:0]          s1_angle_q, s1_angle_d;
    logic                      sat_flag_q, sat_flag_d;

    // stage-2 registers
    state_e                    state_q, state_d;
    logic [ANG_W-1:0]          prev_q, prev_d;
    logic signed [SPD_W-1:0]   acc_q, acc_d;
    logic [WIN_LOG2-1:0]       win_q, win_d;
    logic                      out_valid_q, out_valid_d;
    logic [ANG_W-1:0]          angle_q, angle_d;
    logic signed [DELTA_W-1:0] delta_q, delta_d;
    logic signed [W_TURN-1:0]  turn_q, turn_d;
    logic                      spd_valid_q, spd_valid_d;
    logic signed [SPD_W-1:0]   spd_q, spd_d;

    logic signed [16:0]        theta_cl;
    logic                      clamp;
    logic [ANG_W-1:0]          sum;
    logic signed [DELTA_W-1:0] raw;
    logic signed [DELTA_W-1:0] dnew;

    // Stage 1: clamp theta into [0, pi/2], build full angle, sticky clamp flag
    always_comb begin
        theta_cl   = theta_1st_quad;
        clamp      = 1'b0;
        sum        = '0;
        s1_valid_d = in_valid;
        s1_angle_d = s1_angle_q;
        sat_flag_d = sat_flag_q;
        if (theta_1st_quad < 17'sd0) begin
            theta_cl = '0;
            clamp    = 1'b1;
        end else if (theta_1st_quad > HALF_PI_TH) begin
            theta_cl = HALF_PI_TH;
            clamp    = 1'b1;
        end
        sum = ANG_W'(quadrant) * ANG_W'(HALF_PI_Q) + ANG_W'(unsigned'(theta_cl));
        if (in_valid) begin
            // only q=3 with theta=pi/2 lands on 2pi
            s1_angle_d = (sum >= TWO_PI_A) ? (sum - TWO_PI_A) : sum;
            if (clamp) begin
                sat_flag_d = 1'b1;
            end
        end
    end

    // Stage 2: unwrap FSM, turn counter, windowed speed sum
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        acc_d       = acc_q;
        win_d       = win_q;
        out_valid_d = 1'b0;
        angle_d     = angle_q;
        delta_d     = delta_q;
        turn_d      = turn_q;
        spd_valid_d = 1'b0;
        spd_d       = spd_q;
        raw         = DELTA_W'(s1_angle_q) - DELTA_W'(prev_q);
        dnew        = raw;
        if (s1_valid_q) begin
            if (state_q == ST_FIRST) begin
                dnew = '0;
            end else if (raw > PI_D) begin
                dnew   = raw - TWO_PI_D;
                turn_d = turn_q - W_TURN'(1);
            end else if (raw < -PI_D) begin
                dnew   = raw + TWO_PI_D;
                turn_d = turn_q + W_TURN'(1);
            end
            state_d     = ST_RUN;
            prev_d      = s1_angle_q;
            out_valid_d = 1'b1;
            angle_d     = s1_angle_q;
            delta_d     = dnew;
            if (&win_q) begin
                spd_d       = acc_q + SPD_W'(dnew);
                spd_valid_d = 1'b1;
                acc_d       = '0;
                win_d       = '0;
            end else begin
                acc_d = acc_q + SPD_W'(dnew);
                win_d = win_q + WIN_LOG2'(1);
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_angle_q  <= '0;
            sat_flag_q  <= 1'b0;
            state_q     <= ST_FIRST;
            prev_q      <= '0;
            acc_q       <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            angle_q     <= '0;
            delta_q     <= '0;
            turn_q      <= '0;
            spd_valid_q <= 1'b0;
            spd_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_angle_q  <= s1_angle_d;
            sat_flag_q  <= sat_flag_d;
            state_q     <= state_d;
            prev_q      <= prev_d;
            acc_q       <= acc_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            angle_q     <= angle_d;
            delta_q     <= delta_d;
            turn_q      <= turn_d;
            spd_valid_q <= spd_valid_d;
            spd_q       <= spd_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign angle_out   = angle_q;
    assign delta_out   = delta_q;
    assign turn_cnt    = turn_q;
    assign sat_flag    = sat_flag_q;
    assign speed_valid = spd_valid_q;
    assign speed_out   = spd_q;

endmodule
